alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_mc.sv | 136 +++++++++++++
 tb/tb_alu_mc.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, flag bit positions
// within ALUFlags {N,Z,C,V}, and the controller state encoding.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE,
    ST_MULBUSY
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Ports: clk, reset, start, a, b in; busy, done (pulse), product out.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [CW-1:0]    cnt;

  // Loaded on start; then exactly WIDTH add/shift steps. done is
  // raised on the edge that applies the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      ma      <= '0;
      mb      <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        product <= '0;
        ma      <= a;
        mb      <= b;
        cnt     <= CW'(WIDTH);
        busy    <= 1'b1;
      end else if (busy) begin
        if (mb[0])
          product <= product + ma;
        ma  <= ma << 1;
        mb  <= mb >> 1;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops pipelined one deep, MUL iterative.
// Ports: Start/InReady request, ALUControl/SrcA/SrcB in; ALUResult, ALUFlags, Done out.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  output logic             InReady,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic             Done
);

  localparam int SW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_state_t       state;
  alu_op_t          op_in;
  alu_op_t          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             pend;

  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;
  logic [WIDTH-1:0] bx;
  logic [SW-1:0]    sh;
  logic [3:0]       flags;

  assign op_in = alu_op_t'(ALUControl);

  assign mul_start = Start && (state == ST_IDLE)
                   && !mul_busy && (op_in == OP_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (SrcA),
    .b       (SrcB),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Result of the captured single-cycle op. Extra bit on the
  // shifters catches the last bit shifted out (0 for amount 0).
  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    bx  = (op_q == OP_SUB) ? ~b_q : b_q;
    sh  = b_q[SW-1:0];
    unique case (op_q)
      OP_ADD,
      OP_SUB: begin
        {c, res} = {1'b0, a_q} + {1'b0, bx}
                 + (WIDTH+1)'(op_q == OP_SUB);
        v = (a_q[MSB] == bx[MSB]) && (res[MSB] != a_q[MSB]);
      end
      OP_AND: res = a_q & b_q;
      OP_ORR: res = a_q | b_q;
      OP_EOR: res = a_q ^ b_q;
      OP_LSL: {c, res} = {1'b0, a_q} << sh;
      OP_LSR: {res, c} = {a_q, 1'b0} >> sh;
      OP_MUL: res = '0;
    endcase
    flags         = '0;
    flags[FLAG_N] = res[MSB];
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      InReady   <= 1'b1;
      ALUResult <= '0;
      ALUFlags  <= '0;
      Done      <= 1'b0;
      pend      <= 1'b0;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      Done <= 1'b0;
      pend <= 1'b0;
      if (pend) begin
        ALUResult <= res;
        ALUFlags  <= flags;
        Done      <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (Start) begin
            op_q <= op_in;
            a_q  <= SrcA;
            b_q  <= SrcB;
            if (op_in == OP_MUL) begin
              state   <= ST_MULBUSY;
              InReady <= 1'b0;
            end else begin
              pend <= 1'b1;
            end
          end
        end
        ST_MULBUSY: begin
          if (mul_done) begin
            ALUResult <= mul_prod;
            ALUFlags  <= {mul_prod[MSB],
                          mul_prod == '0, 2'b00};
            Done      <= 1'b1;
            state     <= ST_IDLE;
            InReady   <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32.
// Inputs change 1ns after posedge; outputs sampled 1ns after posedge.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic         InReady;
  logic [2:0]   ALUControl;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [W-1:0] ALUResult;
  logic [3:0]   ALUFlags;
  logic         Done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .InReady    (InReady),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags),
    .Done       (Done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then sample after the next edge.
  task automatic do_op(input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    Start = 1'b1;
    ALUControl = op;
    SrcA = a;
    SrcB = b;
    step();
    Start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Start = 1'b1;
    ALUControl = 3'b000;
    SrcA = 32'd9;
    SrcB = 32'd9;
    step();
    step();
    reset = 1'b0;
    Start = 1'b0;
    checks++;
    if (ALUResult !== 32'd0 || ALUFlags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_out: got %h/%b want 0/0000", ALUResult, ALUFlags);
    end
    checks++;
    if (Done !== 1'b0 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctl: got Done=%b InReady=%b want 0/1", Done, InReady);
    end
    step();
    checks++;
    if (Done !== 1'b0 || ALUResult !== 32'd0) begin
      errors++;
      $display("FAIL reset_start_ignored: got Done=%b res=%h want 0/0", Done, ALUResult);
    end
  endtask

  task automatic test_add();
    do_op(3'b000, 32'd5, 32'd7);
    checks++;
    if (Done !== 1'b1 || ALUResult !== 32'd12 || ALUFlags !== 4'b0000) begin
      errors++;
      $display("FAIL add_5_7: got D=%b %h/%b want 1 0000000c/0000", Done, ALUResult, ALUFlags);
    end
    step();
    checks++;
    if (Done !== 1'b0 || ALUResult !== 32'd12) begin
      errors++;
      $display("FAIL add_hold: got D=%b %h want 0 0000000c", Done, ALUResult);
    end
    do_op(3'b000, 32'h7FFF_FFFF, 32'd1);
    checks++;
    if (ALUResult !== 32'h8000_0000 || ALUFlags !== 4'b1001) begin
      errors++;
      $display("FAIL add_ovf: got %h/%b want 80000000/1001", ALUResult, ALUFlags);
    end
  endtask

  task automatic test_sub();
    do_op(3'b001, 32'd2, 32'd3);
    checks++;
    if (ALUResult !== 32'hFFFF_FFFF || ALUFlags !== 4'b1000) begin
      errors++;
      $display("FAIL sub_2_3: got %h/%b want ffffffff/1000", ALUResult, ALUFlags);
    end
    do_op(3'b001, 32'd3, 32'd3);
    checks++;
    if (ALUResult !== 32'd0 || ALUFlags !== 4'b0110) begin
      errors++;
      $display("FAIL sub_3_3: got %h/%b want 0/0110", ALUResult, ALUFlags);
    end
  endtask

  task automatic test_logic();
    do_op(3'b010, 32'h0000_F0F0, 32'h0000_FF00);
    checks++;
    if (ALUResult !== 32'h0000_F000 || ALUFlags !== 4'b0000) begin
      errors++;
      $display("FAIL and: got %h/%b want 0000f000/0000", ALUResult, ALUFlags);
    end
    do_op(3'b011, 32'h8000_0000, 32'd1);
    checks++;
    if (ALUResult !== 32'h8000_0001 || ALUFlags !== 4'b1000) begin
      errors++;
      $display("FAIL orr: got %h/%b want 80000001/1000", ALUResult, ALUFlags);
    end
    do_op(3'b100, 32'h55, 32'h55);
    checks++;
    if (ALUResult !== 32'd0 || ALUFlags !== 4'b0100) begin
      errors++;
      $display("FAIL eor: got %h/%b want 0/0100", ALUResult, ALUFlags);
    end
  endtask

  task automatic test_shift();
    do_op(3'b101, 32'h8000_0001, 32'd1);
    checks++;
    if (ALUResult !== 32'h2 || ALUFlags !== 4'b0010) begin
      errors++;
      $display("FAIL lsl_1: got %h/%b want 00000002/0010", ALUResult, ALUFlags);
    end
    do_op(3'b110, 32'h1, 32'd0);
    checks++;
    if (ALUResult !== 32'h1 || ALUFlags !== 4'b0000) begin
      errors++;
      $display("FAIL lsr_0: got %h/%b want 00000001/0000", ALUResult, ALUFlags);
    end
    // Only the low 5 bits of SrcB are the amount: 0x21 shifts by 1.
    do_op(3'b110, 32'h3, 32'h21);
    checks++;
    if (ALUResult !== 32'h1 || ALUFlags !== 4'b0010) begin
      errors++;
      $display("FAIL lsr_1: got %h/%b want 00000001/0010", ALUResult, ALUFlags);
    end
  endtask

  task automatic test_mul();
    int dn;
    int busy_bad;
    Start = 1'b1;
    ALUControl = 3'b111;
    SrcA = 32'd13;
    SrcB = 32'd5;
    step();
    Start = 1'b0;
    checks++;
    if (InReady !== 1'b0) begin
      errors++;
      $display("FAIL mul_accept: got InReady=%b want 0", InReady);
    end
    busy_bad = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (InReady !== 1'b0 || Done !== 1'b0) busy_bad++;
      if (i == 5) begin
        Start = 1'b1;
        ALUControl = 3'b000;
        SrcA = 32'd100;
        SrcB = 32'd1;
      end
      if (i == 6) Start = 1'b0;
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL mul_busy: got %0d bad cycles want 0", busy_bad);
    end
    step();
    checks++;
    if (Done !== 1'b1 || ALUResult !== 32'd65 || ALUFlags !== 4'b0000) begin
      errors++;
      $display("FAIL mul_done: got D=%b %h/%b want 1 00000041/0000", Done, ALUResult, ALUFlags);
    end
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL mul_ready: got %b want 1", InReady);
    end
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (Done === 1'b1) dn++;
    end
    checks++;
    if (dn != 0 || ALUResult !== 32'd65) begin
      errors++;
      $display("FAIL mul_single: got %0d extra Done res=%h want 0 00000041", dn, ALUResult);
    end
  endtask

  task automatic test_mul_reset();
    int dn;
    Start = 1'b1;
    ALUControl = 3'b111;
    SrcA = 32'hFFFF;
    SrcB = 32'hFFFF;
    step();
    Start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (ALUResult !== 32'd0 || Done !== 1'b0 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL mulrst: got %h D=%b R=%b want 0 0 1", ALUResult, Done, InReady);
    end
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (Done === 1'b1 || ALUResult !== 32'd0) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL mulrst_quiet: got %0d bad cycles want 0", dn);
    end
    do_op(3'b000, 32'd1, 32'd1);
    checks++;
    if (Done !== 1'b1 || ALUResult !== 32'd2) begin
      errors++;
      $display("FAIL mulrst_add: got D=%b %h want 1 00000002", Done, ALUResult);
    end
  endtask

  task automatic test_back_to_back();
    Start = 1'b1;
    ALUControl = 3'b000;
    SrcA = 32'd10;
    SrcB = 32'd20;
    step();
    ALUControl = 3'b001;
    SrcA = 32'd50;
    SrcB = 32'd8;
    step();
    checks++;
    if (Done !== 1'b1 || ALUResult !== 32'd30) begin
      errors++;
      $display("FAIL b2b_add: got D=%b %h want 1 0000001e", Done, ALUResult);
    end
    ALUControl = 3'b010;
    SrcA = 32'hFF;
    SrcB = 32'h0F;
    step();
    Start = 1'b0;
    checks++;
    if (Done !== 1'b1 || ALUResult !== 32'd42 || ALUFlags !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_sub: got D=%b %h/%b want 1 0000002a/0010", Done, ALUResult, ALUFlags);
    end
    step();
    checks++;
    if (Done !== 1'b1 || ALUResult !== 32'h0F || ALUFlags !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_and: got D=%b %h/%b want 1 0000000f/0000", Done, ALUResult, ALUFlags);
    end
    step();
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got D=%b want 0", Done);
    end
  endtask

  initial begin
    reset = 1'b1;
    Start = 1'b0;
    ALUControl = 3'b000;
    SrcA = '0;
    SrcB = '0;
    #1;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_mul();
    test_mul_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
